// File: rtl/vending_pkg.sv
// Shared constants and types for the vending controller.
// Prices and credit are in Rs.5 units.
package vending_pkg;
    localparam int CREDIT_W = 3;

    typedef logic [CREDIT_W-1:0] credit_t;

    localparam credit_t PRICE0 = 3'd3;
    localparam credit_t PRICE1 = 3'd4;
    localparam credit_t PRICE2 = 3'd5;
    localparam credit_t PRICE3 = 3'd6;

    localparam credit_t COIN5_UNITS  = 3'd1;
    localparam credit_t COIN10_UNITS = 3'd2;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND} state_t;

    // A simultaneous coin5 is swallowed when coin10 is present.
    function automatic credit_t coin_units(input logic c5, input logic c10);
        if (c10)     return COIN10_UNITS;
        else if (c5) return COIN5_UNITS;
        else         return '0;
    endfunction
endpackage

// File: rtl/vend_price_lut.sv
// Combinational item-select to price map.
module vend_price_lut
    import vending_pkg::*;
(
    input  logic [1:0] sel,
    output credit_t    price
);
    always_comb begin
        price = PRICE0;
        case (sel)
            2'd0: price = PRICE0;
            2'd1: price = PRICE1;
            2'd2: price = PRICE2;
            2'd3: price = PRICE3;
            default: price = PRICE0;
        endcase
    end
endmodule

// File: rtl/vending_machine_top.sv
// Four-item coin vending FSM: accumulates Rs.5/Rs.10 credit, dispenses with
// at most one Rs.5 coin of change.
module vending_machine_top
    import vending_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       clock,
    input  logic       reset,
    input  logic       coin5,
    input  logic       coin10,
    output logic       coin_out,
    output logic       dispense
);
    state_t     state;
    credit_t    credit;
    logic [1:0] sel_q;
    logic [1:0] sel_eff;
    credit_t    price;
    credit_t    units;
    credit_t    sum;

    // Only a transaction in progress is bound to the latched selection;
    // otherwise the live sel prices the coin that opens a new one.
    assign sel_eff = (state == COLLECT) ? sel_q : sel;
    assign units   = coin_units(coin5, coin10);
    assign sum     = credit + units;

    vend_price_lut u_lut (
        .sel   (sel_eff),
        .price (price)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            credit   <= '0;
            sel_q    <= '0;
            dispense <= 1'b0;
            coin_out <= 1'b0;
        end else begin
            dispense <= 1'b0;
            coin_out <= 1'b0;
            if (units != '0) begin
                if (state != COLLECT)
                    sel_q <= sel;
                if (sum < price) begin
                    credit <= sum;
                    state  <= COLLECT;
                end else begin
                    credit   <= '0;
                    state    <= VEND;
                    dispense <= 1'b1;
                    coin_out <= (sum != price);
                end
            end else if (state == VEND) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_vending_machine_top.sv
// Directed plus randomized bench for vending_machine_top against a rupee-level model.
module tb_vending_machine_top;
    logic [1:0] sel;
    logic       clock;
    logic       reset;
    logic       coin5;
    logic       coin10;
    logic       coin_out;
    logic       dispense;

    int checks = 0;
    int errors = 0;

    // Reference model state, in rupees.
    int credit_rs = 0;
    int price_rs  = 0;
    logic exp_d, exp_c;

    vending_machine_top dut (
        .sel      (sel),
        .clock    (clock),
        .reset    (reset),
        .coin5    (coin5),
        .coin10   (coin10),
        .coin_out (coin_out),
        .dispense (dispense)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input string tag, input logic rst_n, input logic [1:0] s,
                        input logic c5, input logic c10);
        int val;
        sel = s; coin5 = c5; coin10 = c10; reset = rst_n;
        @(posedge clock);
        #1;
        exp_d = 1'b0;
        exp_c = 1'b0;
        if (!rst_n) begin
            credit_rs = 0;
        end else begin
            val = c10 ? 10 : (c5 ? 5 : 0);
            if (val > 0) begin
                if (credit_rs == 0) price_rs = 15 + 5 * int'(s);
                credit_rs += val;
                if (credit_rs >= price_rs) begin
                    exp_d = 1'b1;
                    exp_c = (credit_rs > price_rs);
                    credit_rs = 0;
                end
            end
        end
        checks++;
        assert (dispense === exp_d) else begin
            errors++;
            $error("FAIL %s dispense: got %b want %b", tag, dispense, exp_d);
        end
        checks++;
        assert (coin_out === exp_c) else begin
            errors++;
            $error("FAIL %s coin_out: got %b want %b", tag, coin_out, exp_c);
        end
    endtask

    initial begin
        sel = 0; coin5 = 0; coin10 = 0; reset = 0;
        step("reset0", 0, 0, 0, 0);
        step("reset_coin", 0, 0, 0, 1);
        step("idle", 1, 0, 0, 0);

        // item 0, overpay by one unit
        step("i0_c1", 1, 0, 0, 1);
        step("i0_c2", 1, 0, 0, 1);
        step("i0_after", 1, 0, 0, 0);

        // item 1: 10,5,10
        step("i1_c1", 1, 1, 0, 1);
        step("i1_c2", 1, 1, 1, 0);
        step("i1_c3", 1, 1, 0, 1);
        step("i1_after", 1, 1, 0, 0);

        // item 2 x3 coin10, then item 3 chained straight after
        step("i2_c1", 1, 2, 0, 1);
        step("i2_c2", 1, 2, 0, 1);
        step("i2_c3", 1, 2, 0, 1);
        step("i3_c1", 1, 3, 1, 0);
        step("i3_c2", 1, 3, 0, 1);
        step("i3_c3", 1, 3, 0, 1);
        step("i3_c4", 1, 3, 0, 1);
        step("i3_after", 1, 3, 0, 0);

        // exact payment on item 3
        step("ex_c1", 1, 3, 0, 1);
        step("ex_c2", 1, 3, 0, 1);
        step("ex_c3", 1, 3, 0, 1);

        // sel change mid-transaction must not reprice
        step("sl_c1", 1, 3, 0, 1);
        step("sl_c2", 1, 0, 0, 1);
        step("sl_c3", 1, 0, 0, 1);

        // both coins together credit only Rs.10
        step("both_c1", 1, 1, 1, 1);
        step("both_c2", 1, 1, 0, 1);

        // reset mid-transaction
        step("rst_c1", 1, 2, 0, 1);
        step("rst_mid", 0, 2, 0, 0);
        step("rst_p1", 1, 2, 0, 1);
        step("rst_p2", 1, 2, 0, 1);
        step("rst_p3", 1, 2, 0, 1);
        step("rst_after", 1, 2, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r, a, b;
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 39) != 0);
            a = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 2) == 0);
            step("rand", r, s, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
